uart_tx_seq: RTL and testbench

UART_TX_SEQ -- requirements
Module: uart_tx_seq

---
 rtl/uart_tx_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_tx_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_seq.sv
// uart_tx_seq: UART transmitter with a transmit FIFO and frame sequencer.
//
// Bytes written through wr_en_i/wr_data_i are queued in a FIFO. While
// send_i is high, queued bytes are sent as frames:
//   start bit (0), DATA_W data bits LSB-first, optional parity, 1 or 2 stop bits.
// Frames run back-to-back with no idle bit. When the last frame ends and
// the FIFO is empty, done_o and we_reg_control_o pulse together, so the
// control register can clear its send bit.
//
// Ports
//   clk_i            : clock; all state changes on the rising edge
//   rst_i            : asynchronous active-high reset
//   baud_tick_i      : one-cycle pulse per bit period
//   wr_en_i          : FIFO write request
//   wr_data_i        : byte to enqueue
//   send_i           : level enable for launching frames
//   parity_mode_i    : 00 none, 01 even, 10 odd, 11 none
//   stop2_i          : 0 one stop bit, 1 two stop bits
//   tx_o             : registered serial line, idles high
//   busy_o           : high whenever the sequencer is not IDLE
//   full_o, empty_o  : FIFO status
//   count_o          : FIFO occupancy
//   wr_ovf_o         : one-cycle pulse after a rejected write
//   we_reg_control_o : one-cycle pulse requesting the send bit be cleared
//   done_o           : one-cycle pulse, same cycle as we_reg_control_o
module uart_tx_seq #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            baud_tick_i,
    input  logic                            wr_en_i,
    input  logic [DATA_W-1:0]               wr_data_i,
    input  logic                            send_i,
    input  logic [1:0]                      parity_mode_i,
    input  logic                            stop2_i,
    output logic                            tx_o,
    output logic                            busy_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
    output logic                            wr_ovf_o,
    output logic                            we_reg_control_o,
    output logic                            done_o
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int BCW = $clog2(DATA_W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              wr_ovf_q;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    // Acceptance looks at occupancy before any pop in the same cycle.
    assign push    = wr_en_i && !full_o;
    assign head    = mem[rd_ptr_q];

    // Storage is data only and carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_ovf_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            wr_ovf_q <= wr_en_i && full_o;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic              tx_q;
    logic              tx_d;
    logic [DATA_W-1:0] shift_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [BCW-1:0]    bit_cnt_d;
    logic              stop_cnt_q;
    logic              stop_cnt_d;
    logic              par_en_q;
    logic              par_q;
    logic              stop2_q;
    logic              done_q;
    logic              done_d;
    logic              launch;
    logic              shift_adv;
    logic              can_launch;

    assign pop        = launch;
    assign can_launch = send_i && !empty_o;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
        launch     = 1'b0;
        shift_adv  = 1'b0;

        if (baud_tick_i) begin
            case (state_q)
                IDLE: begin
                    if (can_launch) begin
                        launch  = 1'b1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end
                end
                START: begin
                    tx_d      = shift_q[0];
                    shift_adv = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    // bit_cnt_q is the index of the bit currently on the line.
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_adv = 1'b1;
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                PARITY: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
                STOP: begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        // Final stop tick: chain straight into the next start bit.
                        if (can_launch) begin
                            launch  = 1'b1;
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                        done_d = empty_o;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            done_q     <= done_d;
            // Frame options are frozen at launch so later input changes
            // cannot disturb the frame in flight.
            if (launch) begin
                par_en_q <= (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
                par_q    <= parity_bit(head, parity_mode_i == 2'b10);
                stop2_q  <= stop2_i;
            end
        end
    end

    // Shift register is data only and carries no reset.
    always_ff @(posedge clk_i) begin
        if (launch) begin
            shift_q <= head;
        end else if (shift_adv) begin
            shift_q <= shift_q >> 1;
        end
    end

    assign tx_o             = tx_q;
    assign busy_o           = (state_q != IDLE);
    assign count_o          = count_q;
    assign wr_ovf_o         = wr_ovf_q;
    assign we_reg_control_o = done_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_uart_tx_seq.sv
// tb_uart_tx_seq: directed bench for uart_tx_seq (DATA_W=8, FIFO_DEPTH=4).
// Expected line bits are queued when a frame is set up and popped by a
// monitor on every baud tick that the DUT spends inside a frame.
`timescale 1ns/1ps
module tb_uart_tx_seq;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int TICK_DIV   = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              baud_tick_i = 1'b0;
    logic              wr_en_i = 1'b0;
    logic [DATA_W-1:0] wr_data_i = '0;
    logic              send_i = 1'b0;
    logic [1:0]        parity_mode_i = 2'b00;
    logic              stop2_i = 1'b0;
    logic              tx_o;
    logic              busy_o;
    logic              full_o;
    logic              empty_o;
    logic [CW-1:0]     count_o;
    logic              wr_ovf_o;
    logic              we_reg_control_o;
    logic              done_o;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   ovf_cnt = 0;
    int   busy_fall = 0;
    int   tick_cnt = 0;
    logic tick_d = 1'b0;
    logic busy_prev = 1'b0;
    logic mon_on = 1'b0;
    logic exp_q[$];

    logic [DATA_W-1:0] tab_d [3] = '{8'h07, 8'h3C, 8'h5A};
    logic [1:0]        tab_m [3] = '{2'b01, 2'b11, 2'b10};
    logic              tab_s [3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk_i = ~clk_i;

    uart_tx_seq #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .baud_tick_i      (baud_tick_i),
        .wr_en_i          (wr_en_i),
        .wr_data_i        (wr_data_i),
        .send_i           (send_i),
        .parity_mode_i    (parity_mode_i),
        .stop2_i          (stop2_i),
        .tx_o             (tx_o),
        .busy_o           (busy_o),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .count_o          (count_o),
        .wr_ovf_o         (wr_ovf_o),
        .we_reg_control_o (we_reg_control_o),
        .done_o           (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Baud tick: one cycle high every TICK_DIV cycles, driven just after the edge.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (tick_cnt == TICK_DIV - 1) begin
            baud_tick_i = 1'b1;
            tick_cnt    = 0;
        end else begin
            baud_tick_i = 1'b0;
            tick_cnt++;
        end
    end

    always @(posedge clk_i) tick_d <= baud_tick_i;

    // Monitor: after every processed tick, a busy DUT must put the next
    // expected bit on the line; an idle DUT must hold the line high.
    always @(negedge clk_i) begin
        if (mon_on) begin
            logic have;
            chk("done_we_pair", we_reg_control_o, done_o);
            if (done_o === 1'b1) done_cnt++;
            if (wr_ovf_o === 1'b1) ovf_cnt++;
            if (busy_prev && !busy_o) busy_fall++;
            busy_prev = busy_o;
            if (tick_d && !rst_i) begin
                if (busy_o) begin
                    have = (exp_q.size() != 0);
                    chk("bit_pending", have, 1);
                    if (have) chk("tx_bit", tx_o, exp_q.pop_front());
                end else begin
                    chk("idle_line", tx_o, 1);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] d, input logic [1:0] mode, input logic two);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) exp_q.push_back(d[i]);
        if (mode == 2'b01) exp_q.push_back(^d);
        else if (mode == 2'b10) exp_q.push_back(~(^d));
        exp_q.push_back(1'b1);
        if (two) exp_q.push_back(1'b1);
    endtask

    task automatic write_byte(input logic [DATA_W-1:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        step();
        wr_en_i   = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && busy_o === 1'b0) && n < 2000) begin
            step();
            n++;
        end
        chk(tag, (n >= 2000), 0);
        step(3);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, (n >= 200), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int o0;
        int f0;
        int n;

        // Reset state
        #1 rst_i = 1'b1;
        step(2);
        chk("rst_tx", tx_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_ovf", wr_ovf_o, 0);
        chk("rst_we", we_reg_control_o, 0);
        chk("rst_done", done_o, 0);
        rst_i  = 1'b0;
        mon_on = 1'b1;
        step(2);

        // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
        d0 = done_cnt;
        write_byte(8'hA5);
        chk("a5_count", count_o, 1);
        chk("a5_empty", empty_o, 0);
        push_frame(8'hA5, 2'b00, 1'b0);
        send_i = 1'b1;
        wait_end("a5_timeout");
        send_i = 1'b0;
        chk("a5_done", done_cnt - d0, 1);
        chk("a5_idle_tx", tx_o, 1);
        chk("a5_idle_busy", busy_o, 0);

        // Odd parity, two stops; inputs changed mid-frame must not matter
        d0 = done_cnt;
        parity_mode_i = 2'b10;
        stop2_i       = 1'b1;
        write_byte(8'h03);
        push_frame(8'h03, 2'b10, 1'b1);
        send_i = 1'b1;
        wait_busy("odd_launch");
        parity_mode_i = 2'b00;
        stop2_i       = 1'b0;
        wait_end("odd_timeout");
        send_i = 1'b0;
        chk("odd_done", done_cnt - d0, 1);

        // Table of further modes: even, 11 (as none) with two stops, odd
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt;
            parity_mode_i = tab_m[i];
            stop2_i       = tab_s[i];
            write_byte(tab_d[i]);
            push_frame(tab_d[i], tab_m[i], tab_s[i]);
            send_i = 1'b1;
            wait_end("tab_timeout");
            send_i = 1'b0;
            chk("tab_done", done_cnt - d0, 1);
        end
        parity_mode_i = 2'b00;
        stop2_i       = 1'b0;

        // Fill to full, overflow on the fifth write, then drain back-to-back
        o0 = ovf_cnt;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        chk("fill_count", count_o, 4);
        chk("fill_full", full_o, 1);
        chk("fill_no_ovf", wr_ovf_o, 0);
        wr_en_i   = 1'b1;
        wr_data_i = 8'h55;
        step();
        wr_en_i   = 1'b0;
        chk("ovf_pulse", wr_ovf_o, 1);
        chk("ovf_count", count_o, 4);
        step();
        chk("ovf_one_cycle", wr_ovf_o, 0);
        chk("ovf_pulses", ovf_cnt - o0, 1);
        d0 = done_cnt;
        f0 = busy_fall;
        push_frame(8'h11, 2'b00, 1'b0);
        push_frame(8'h22, 2'b00, 1'b0);
        push_frame(8'h33, 2'b00, 1'b0);
        push_frame(8'h44, 2'b00, 1'b0);
        send_i = 1'b1;
        wait_end("b2b_timeout");
        send_i = 1'b0;
        chk("b2b_done", done_cnt - d0, 1);
        chk("b2b_no_gap", busy_fall - f0, 1);
        chk("b2b_empty", empty_o, 1);
        chk("b2b_count", count_o, 0);

        // Full FIFO: write lands on the launch pop cycle
        o0 = ovf_cnt;
        d0 = done_cnt;
        write_byte(8'hAA);
        write_byte(8'hBB);
        write_byte(8'hCC);
        write_byte(8'hDD);
        push_frame(8'hAA, 2'b00, 1'b0);
        push_frame(8'hBB, 2'b00, 1'b0);
        push_frame(8'hCC, 2'b00, 1'b0);
        push_frame(8'hDD, 2'b00, 1'b0);
        n = 0;
        while (baud_tick_i !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("wp_tick_found", (n >= 20), 0);
        wr_en_i   = 1'b1;
        wr_data_i = 8'hEE;
        send_i    = 1'b1;
        step();
        wr_en_i   = 1'b0;
        chk("wp_count", count_o, 3);
        chk("wp_ovf", wr_ovf_o, 1);
        chk("wp_full", full_o, 0);
        wait_end("wp_timeout");
        send_i = 1'b0;
        chk("wp_ovf_pulses", ovf_cnt - o0, 1);
        chk("wp_done", done_cnt - d0, 1);

        // Reset during data bit 3 of 0xF0 (bit 3 is 0 on the line)
        d0 = done_cnt;
        write_byte(8'hF0);
        push_frame(8'hF0, 2'b00, 1'b0);
        send_i = 1'b1;
        wait_busy("rst_launch");
        write_byte(8'h99);
        n = 0;
        while (exp_q.size() > 5 && n < 200) begin
            step();
            n++;
        end
        chk("rst_bit3_reached", (n >= 200), 0);
        chk("rst_bit3_line", tx_o, 0);
        chk("rst_pre_count", count_o, 1);
        rst_i  = 1'b1;
        send_i = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_tx", tx_o, 1);
        chk("arst_count", count_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_empty", empty_o, 1);
        step(3);
        rst_i = 1'b0;
        step(4);
        chk("arst_no_done", done_cnt - d0, 0);
        write_byte(8'h3A);
        push_frame(8'h3A, 2'b00, 1'b0);
        send_i = 1'b1;
        wait_end("post_rst_timeout");
        send_i = 1'b0;
        chk("post_rst_done", done_cnt - d0, 1);

        // send_i dropped during frame 1 of 2
        d0 = done_cnt;
        write_byte(8'h81);
        write_byte(8'h42);
        push_frame(8'h81, 2'b00, 1'b0);
        send_i = 1'b1;
        wait_busy("drop_launch");
        send_i = 1'b0;
        wait_end("drop_timeout");
        chk("drop_count", count_o, 1);
        chk("drop_empty", empty_o, 0);
        chk("drop_busy", busy_o, 0);
        chk("drop_no_done", done_cnt - d0, 0);
        chk("drop_tx", tx_o, 1);
        push_frame(8'h42, 2'b00, 1'b0);
        send_i = 1'b1;
        wait_end("drop2_timeout");
        send_i = 1'b0;
        chk("drop2_done", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
